refill_cache_instrucoes: RTL and testbench

Miss-refill controller for the direct-mapped instruction cache: 32 lines × 128 bits (4 words), index PC[8:4], tag PC[31:9]. When the cache reports a miss, the block:
- latches the missing line address;
- fetches the four words from instruction memory over a req/ack handshake;
- writes the assembled 128-bit line, tag and valid bit into the cache in one cycle.

It sits between the fetch-stage cache and the instruction memory. It is the only writer of the cache arrays apart from reset.

---
 rtl/refill_cache_instrucoes.sv | 154 +++++++++++++++
 tb/tb_refill_cache_instrucoes.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/refill_cache_instrucoes.sv
// -----------------------------------------------------------------------------
// refill_cache_instrucoes
//
// Miss-refill controller for the direct-mapped instruction cache
// (32 lines x 128 bits, index pc[8:4], tag pc[31:9] with the default width).
// On a cache miss it latches the line base, reads the four words of the line
// from instruction memory in ascending order over a req/ack handshake, and then
// writes line data, index and tag into the cache with a single fill_we pulse.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   miss_cache            miss indication from the cache (combinational there)
//   pc                    current fetch PC, sampled only when a miss is accepted
//   mem_req / mem_addr    registered read request and word address to memory
//   mem_ack / mem_rdata   one-cycle acknowledge with read data in the same cycle
//   fill_we               one-cycle line write strobe to the cache
//   fill_index/_tag/_data line being written; registered, qualified by fill_we
//   ocupado               high whenever the controller is not idle
//   contador_misses       number of refills started, wraps silently
// -----------------------------------------------------------------------------
module refill_cache_instrucoes #(
    parameter int INDEX_BITS = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   miss_cache,
    input  logic [31:0]            pc,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   fill_we,
    output logic [INDEX_BITS-1:0]  fill_index,
    output logic [27-INDEX_BITS:0] fill_tag,
    output logic [127:0]           fill_data,
    output logic                   ocupado,
    output logic [31:0]            contador_misses
);

    typedef enum logic [1:0] {
        OCIOSO,   // waiting for a miss
        BUSCA,    // fetching the four words of the line
        ESCRITA,  // fill_we pulse, line goes into the cache
        CONCLUI   // cache already hits on the new line; miss ignored
    } estado_t;

    estado_t estado, estado_prox;

    logic [27:0] linha;       // latched line address, pc[31:4]
    logic [1:0]  palavra;     // word currently being fetched
    logic [95:0] buffer;      // words 0..2 collected so far
    logic        aceita_miss;
    logic        aceita_ack;
    logic        ultima_palavra;

    // Low PC bits select a byte inside the line and play no role in a refill.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[3:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with <= so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and datapath strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        estado_prox    = estado;
        aceita_miss    = 1'b0;
        aceita_ack     = 1'b0;
        ultima_palavra = 1'b0;
        case (estado)
            OCIOSO: begin
                if (miss_cache) begin
                    aceita_miss = 1'b1;
                    estado_prox = BUSCA;
                end
            end
            BUSCA: begin
                // An ack only counts while a request is outstanding.
                if (mem_req && mem_ack) begin
                    aceita_ack = 1'b1;
                    if (palavra == 2'd3) begin
                        ultima_palavra = 1'b1;
                        estado_prox    = ESCRITA;
                    end
                end
            end
            ESCRITA: estado_prox = CONCLUI;
            CONCLUI: estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered datapath and outputs
    // -------------------------------------------------------------------------
    // NOTE: the line buffer is reset along with the control registers; it is
    // small, and a known value keeps fill_data free of X after a mid-refill reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            linha           <= '0;
            palavra         <= '0;
            buffer          <= '0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            fill_we         <= 1'b0;
            fill_index      <= '0;
            fill_tag        <= '0;
            fill_data       <= '0;
            ocupado         <= 1'b0;
            contador_misses <= '0;
        end else begin
            ocupado <= (estado_prox != OCIOSO);
            fill_we <= aceita_ack && ultima_palavra;

            if (aceita_miss) begin
                linha           <= pc[31:4];
                palavra         <= 2'd0;
                mem_req         <= 1'b1;
                mem_addr        <= {pc[31:4], 4'b0000};
                contador_misses <= contador_misses + 32'd1;
            end

            if (aceita_ack) begin
                if (ultima_palavra) begin
                    // Last word goes straight into the line; request drops.
                    mem_req    <= 1'b0;
                    fill_data  <= {mem_rdata, buffer};
                    fill_index <= linha[INDEX_BITS-1:0];
                    fill_tag   <= linha[27:INDEX_BITS];
                end else begin
                    // Shift in from the top: after three acks the buffer holds
                    // {word2, word1, word0} in line order.
                    buffer   <= {mem_rdata, buffer[95:32]};
                    palavra  <= palavra + 2'd1;
                    mem_addr <= mem_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_refill_cache_instrucoes.sv
// -----------------------------------------------------------------------------
// Self-checking bench for refill_cache_instrucoes. A behavioural memory in the
// bench answers each request after a chosen latency; expected addresses, line
// contents, index/tag, strobe timing and miss count come from plain arithmetic
// on the PC and the words handed out.
// -----------------------------------------------------------------------------
module tb_refill_cache_instrucoes;

    logic         clock;
    logic         reset;
    logic         miss_cache;
    logic [31:0]  pc;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         fill_we;
    logic [4:0]   fill_index;
    logic [22:0]  fill_tag;
    logic [127:0] fill_data;
    logic         ocupado;
    logic [31:0]  contador_misses;

    int           n_checks;
    int           n_fails;
    int           fill_we_pulses;
    logic [31:0]  model_misses;
    logic [127:0] model_line;

    refill_cache_instrucoes #(.INDEX_BITS(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .miss_cache      (miss_cache),
        .pc              (pc),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .fill_we         (fill_we),
        .fill_index      (fill_index),
        .fill_tag        (fill_tag),
        .fill_data       (fill_data),
        .ocupado         (ocupado),
        .contador_misses (contador_misses)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every cycle in which the write strobe is seen high.
    always @(negedge clock) begin
        if (fill_we === 1'b1) fill_we_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete refill, entered and left on a falling edge. lat[k] is the
    // number of cycles the request for word k stays up before it is acked.
    // hold_miss keeps miss_cache high and moves pc around during the refill.
    task automatic do_refill(input logic [31:0] pc_miss, input logic [3:0][7:0] lat,
                             input logic [3:0][31:0] words, input bit hold_miss);
        logic [31:0] base;
        int          pulses_before;
        int          edges;
        base          = {pc_miss[31:4], 4'b0000};
        pulses_before = fill_we_pulses;
        edges         = 0;

        miss_cache = 1'b1;
        pc         = pc_miss;
        @(posedge clock); @(negedge clock);
        model_misses = model_misses + 32'd1;
        check("req_after_miss", mem_req, 1'b1);
        check("addr_after_miss", mem_addr, base);
        check("busy_after_miss", ocupado, 1'b1);
        check("miss_count", contador_misses, model_misses);

        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= int'(lat[k]); c++) begin
                miss_cache = hold_miss;
                pc         = hold_miss ? 32'h0000_2000 : $urandom;
                check("req_held", mem_req, 1'b1);
                check("addr_word", mem_addr, base + 32'(4 * k));
                check("no_early_we", fill_we, 1'b0);
                mem_ack   = (c == int'(lat[k]));
                mem_rdata = (c == int'(lat[k])) ? words[k] : $urandom;
                @(posedge clock); @(negedge clock);
                edges++;
                mem_ack = 1'b0;
            end
        end

        model_line = {words[3], words[2], words[1], words[0]};
        check("we_after_last_ack", fill_we, 1'b1);
        check("we_edge_count", edges, lat[0] + lat[1] + lat[2] + lat[3]);
        check("req_dropped", mem_req, 1'b0);
        check("fill_index", fill_index, (base >> 4) % 32);
        check("fill_tag", fill_tag, base >> 9);
        check("fill_data", fill_data, model_line);

        @(posedge clock); @(negedge clock);
        check("we_single_cycle", fill_we, 1'b0);
        check("busy_conclui", ocupado, 1'b1);
        check("data_stable", fill_data, model_line);

        @(posedge clock); @(negedge clock);
        check("idle_after_refill", ocupado, 1'b0);
        check("req_idle", mem_req, 1'b0);
        check("one_pulse", fill_we_pulses - pulses_before, 1);
        check("no_second_refill", contador_misses, model_misses);
        miss_cache = 1'b0;
    endtask

    initial begin
        logic [3:0][7:0]  lat;
        logic [3:0][31:0] words;

        n_checks       = 0;
        n_fails        = 0;
        fill_we_pulses = 0;
        model_misses   = '0;
        model_line     = '0;
        reset          = 1'b1;
        miss_cache     = 1'b0;
        pc             = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;

        repeat (2) @(negedge clock);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_we", fill_we, 1'b0);
        check("rst_data", fill_data, 128'h0);
        check("rst_busy", ocupado, 1'b0);
        check("rst_count", contador_misses, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Single-cycle acks, known data.
        lat   = {8'd1, 8'd1, 8'd1, 8'd1};
        words = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_refill(32'h0000_1234, lat, words, 1'b0);

        // Three cycles per word at the top of the address space.
        lat = {8'd3, 8'd3, 8'd3, 8'd3};
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        do_refill(32'hFFFF_FFF0, lat, words, 1'b0);

        // Miss held high and pc moved during the refill.
        lat = {8'd2, 8'd1, 8'd3, 8'd1};
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        do_refill(32'h0000_0588, lat, words, 1'b1);

        // Spurious ack while idle.
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_DEAD;
        repeat (2) begin
            @(posedge clock); @(negedge clock);
            check("spurious_busy", ocupado, 1'b0);
            check("spurious_req", mem_req, 1'b0);
            check("spurious_we", fill_we, 1'b0);
        end
        mem_ack = 1'b0;
        check("spurious_count", contador_misses, model_misses);
        check("spurious_data", fill_data, model_line);

        // Reset after two acks.
        miss_cache = 1'b1;
        pc         = 32'h0000_7770;
        @(posedge clock); @(negedge clock);
        miss_cache = 1'b0;
        mem_ack    = 1'b1;
        repeat (2) begin
            mem_rdata = $urandom;
            @(posedge clock); @(negedge clock);
        end
        mem_ack = 1'b0;
        check("pre_reset_busy", ocupado, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_misses = '0;
        model_line   = '0;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_busy", ocupado, 1'b0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_count", contador_misses, 32'h0);
        check("midrst_data", fill_data, 128'h0);
        @(negedge clock);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_BEEF;
        @(posedge clock); @(negedge clock);
        mem_ack = 1'b0;
        check("late_ack_ignored", ocupado, 1'b0);
        lat = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        do_refill(32'h0000_0040, lat, words, 1'b0);

        // Randomized back-to-back refills.
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 4; k++) begin
                lat[k]   = 8'($urandom_range(1, 4));
                words[k] = $urandom;
            end
            do_refill($urandom, lat, words, 1'($urandom_range(0, 1)));
        end

        // Counter wrap through a backdoor preset.
        force dut.contador_misses = 32'hFFFF_FFFF;
        #1 release dut.contador_misses;
        model_misses = 32'hFFFF_FFFF;
        check("preset_count", contador_misses, model_misses);
        @(negedge clock);
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        do_refill($urandom, lat, words, 1'b0);
        check("count_wrapped", contador_misses, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
